// File: rtl/player_link_tx_if.sv
// Byte stream from the player-state packetizer into the serial link transmitter.
// Valid/ready handshake: a byte moves on a clock edge where tx_valid and tx_ready are both high.
interface player_link_tx_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/player_link_tx.sv
// Snapshots local player state on a due frame tick and streams a checksummed 8-byte packet.
// Latency: B0 is presented the cycle after the due tick; with tx_ready high B0..B7 take 8 cycles.
// Backpressure: tx_ready low stalls the current byte in place; due ticks while busy are counted and skipped.
module player_link_tx #(
  parameter int         SEND_DIV  = 1,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic [11:0]      char_x,
  input  logic [11:0]      char_y,
  input  logic [3:0]       current_health,
  input  logic [3:0]       char_aggro,
  input  logic             flip_h,
  input  logic [1:0]       char_class,
  input  logic             game_start,
  input  logic [6:0]       boss_hp,
  player_link_tx_if.master tx,
  output logic             busy,
  output logic             pkt_done,
  output logic [7:0]       overrun_cnt
);

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [3:0]  hp;
    logic [3:0]  aggro;
    logic        flip;
    logic        start;
    logic [1:0]  cls;
    logic [6:0]  boss;
  } snap_t;

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state;
  snap_t      snap;
  logic [7:0] div_cnt;
  logic [2:0] byte_idx;
  logic [2:0] nxt_idx;
  logic [7:0] nxt_byte;
  logic [7:0] csum;
  logic       due;
  logic       xfer;

  assign due     = frame_tick && (div_cnt == 8'(SEND_DIV - 1));
  assign xfer    = tx.tx_valid && tx.tx_ready;
  assign nxt_idx = byte_idx + 3'd1;

  assign csum = SYNC_BYTE ^ snap.x[11:4] ^ {snap.x[3:0], snap.y[11:8]} ^ snap.y[7:0] ^
                {snap.hp, snap.aggro} ^ {snap.flip, snap.start, snap.cls, 4'h0} ^ {1'b0, snap.boss};

  // tx_data is registered, so the byte after the one being transferred is prepared here
  always_comb begin
    nxt_byte = SYNC_BYTE;
    case (nxt_idx)
      3'd1:    nxt_byte = snap.x[11:4];
      3'd2:    nxt_byte = {snap.x[3:0], snap.y[11:8]};
      3'd3:    nxt_byte = snap.y[7:0];
      3'd4:    nxt_byte = {snap.hp, snap.aggro};
      3'd5:    nxt_byte = {snap.flip, snap.start, snap.cls, 4'h0};
      3'd6:    nxt_byte = {1'b0, snap.boss};
      3'd7:    nxt_byte = csum;
      default: nxt_byte = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      snap        <= '0;
      div_cnt     <= 8'd0;
      byte_idx    <= 3'd0;
      tx.tx_valid <= 1'b0;
      tx.tx_data  <= 8'h00;
      busy        <= 1'b0;
      pkt_done    <= 1'b0;
      overrun_cnt <= 8'd0;
    end else begin
      pkt_done <= 1'b0;
      if (frame_tick) div_cnt <= due ? 8'd0 : div_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (due) begin
            snap        <= {char_x, char_y, current_health, char_aggro,
                            flip_h, game_start, char_class, boss_hp};
            byte_idx    <= 3'd0;
            tx.tx_valid <= 1'b1;
            tx.tx_data  <= SYNC_BYTE;
            busy        <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          // A due tick that lands on the B7 transfer edge is still an overrun
          if (due && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
          if (xfer) begin
            if (byte_idx == 3'd7) begin
              tx.tx_valid <= 1'b0;
              busy        <= 1'b0;
              pkt_done    <= 1'b1;
              state       <= IDLE;
            end else begin
              byte_idx   <= nxt_idx;
              tx.tx_data <= nxt_byte;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_player_link_tx.sv
// Randomized bench for player_link_tx: a packet-level model queues expected bytes and state,
// a negedge monitor pops and compares every transferred byte and the status outputs.
module tb_player_link_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        tick3;
  logic [11:0] char_x;
  logic [11:0] char_y;
  logic [3:0]  hp;
  logic [3:0]  aggro;
  logic        flip_h;
  logic [1:0]  cls;
  logic        game_start;
  logic [6:0]  boss_hp;
  logic        busy, pkt_done, busy3, done3;
  logic [7:0]  ovr, ovr3;

  always #5 clk = ~clk;

  player_link_tx_if link ();
  player_link_tx_if link3 ();
  assign link3.tx_ready = 1'b1;

  player_link_tx dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .char_x(char_x), .char_y(char_y), .current_health(hp), .char_aggro(aggro),
    .flip_h(flip_h), .char_class(cls), .game_start(game_start), .boss_hp(boss_hp),
    .tx(link), .busy(busy), .pkt_done(pkt_done), .overrun_cnt(ovr)
  );

  player_link_tx #(.SEND_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .frame_tick(tick3),
    .char_x(char_x), .char_y(char_y), .current_health(hp), .char_aggro(aggro),
    .flip_h(flip_h), .char_class(cls), .game_start(game_start), .boss_hp(boss_hp),
    .tx(link3), .busy(busy3), .pkt_done(done3), .overrun_cnt(ovr3)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_done1  = 0;
  int n_done3  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packets are lists of bytes; the link is "busy" while bytes remain.
  logic [7:0] exp_q[$];
  int         m_rem;
  int         m_ovr;
  bit         m_done;
  int         m_before;
  bit         m_xf;

  function automatic void push_pkt();
    logic [7:0] b[8];
    logic [7:0] x;
    b[0] = 8'hA5;
    b[1] = 8'(char_x / 16);
    b[2] = 8'((char_x % 16) * 16 + char_y / 256);
    b[3] = 8'(char_y % 256);
    b[4] = 8'(hp * 16 + aggro);
    b[5] = 8'(flip_h * 128 + game_start * 64 + cls * 16);
    b[6] = 8'(boss_hp);
    x = 8'h00;
    for (int i = 0; i < 7; i++) x = x ^ b[i];
    b[7] = x;
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_rem  = 0;
      m_ovr  = 0;
      m_done = 0;
    end else begin
      m_before = m_rem;
      m_xf     = (m_rem > 0) && link.tx_ready;
      m_done   = m_xf && (m_rem == 1);
      if (m_xf) m_rem = m_rem - 1;
      if (frame_tick) begin
        if (m_before > 0) begin
          if (m_ovr < 255) m_ovr = m_ovr + 1;
        end else begin
          push_pkt();
          m_rem = 8;
        end
      end
    end
  end

  bit         hold;
  logic [7:0] hold_dat;

  always @(negedge clk) begin
    if (!rst) begin
      hold = 0;
    end else begin
      check("busy", busy, m_rem > 0);
      check("tx_valid", link.tx_valid, m_rem > 0);
      check("pkt_done", pkt_done, m_done);
      check("overrun_cnt", ovr, m_ovr);
      if (hold) begin
        check("stall_valid", link.tx_valid, 1);
        check("stall_data", link.tx_data, hold_dat);
      end
      if (link.tx_valid && link.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_byte: got %0h, expected no transfer at %0t", link.tx_data, $time);
        end else begin
          check("tx_byte", link.tx_data, exp_q.pop_front());
        end
      end
      hold     = link.tx_valid && !link.tx_ready;
      hold_dat = link.tx_data;
      if (pkt_done) n_done1++;
      if (done3) n_done3++;
    end
  end

  task automatic step(input bit t);
    frame_tick = t;
    @(posedge clk);
    #2;
    frame_tick = 1'b0;
  endtask

  task automatic rand_inputs();
    char_x     = 12'($urandom_range(0, 4095));
    char_y     = 12'($urandom_range(0, 4095));
    hp         = 4'($urandom_range(0, 15));
    aggro      = 4'($urandom_range(0, 15));
    flip_h     = 1'($urandom_range(0, 1));
    cls        = 2'($urandom_range(0, 3));
    game_start = 1'($urandom_range(0, 1));
    boss_hp    = 7'($urandom_range(0, 127));
  endtask

  task automatic basic_inputs();
    char_x = 12'h123; char_y = 12'h456; hp = 4'd9; aggro = 4'd3;
    flip_h = 1'b1; game_start = 1'b1; cls = 2'b10; boss_hp = 7'd100;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
      step(0);
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got busy after 400 cycles, expected idle", name);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(0);
    rst = 1'b1;
  endtask

  int bc;
  int d0;

  initial begin
    rst = 1'b0; frame_tick = 1'b0; tick3 = 1'b0; link.tx_ready = 1'b0;
    basic_inputs();
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx_valid", link.tx_valid, 0);
    check("rst_tx_data", link.tx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_overrun", ovr, 0);
    rst = 1'b1;
    step(0);

    // Basic packet with tx_ready held high
    link.tx_ready = 1'b1;
    d0 = n_done1;
    step(1);
    bc = 0;
    for (int i = 0; i < 12; i++) begin
      bc += int'(busy);
      step(0);
    end
    check("basic_busy_cycles", bc, 8);
    check("basic_done_pulses", n_done1 - d0, 1);

    // Backpressure, with inputs changing mid-packet
    for (int p = 0; p < 20; p++) begin
      if (p > 0) rand_inputs();
      link.tx_ready = 1'($urandom_range(0, 1));
      step(1);
      for (int i = 0; i < 300 && busy; i++) begin
        link.tx_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) rand_inputs();
        step(0);
      end
    end
    link.tx_ready = 1'b1;
    wait_done("backpressure_drain");

    // Random mix of ticks, backpressure and input changes
    for (int i = 0; i < 1500; i++) begin
      link.tx_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) rand_inputs();
      step($urandom_range(0, 5) == 0);
    end
    link.tx_ready = 1'b1;
    wait_done("random_drain");

    // Overrun saturation
    do_reset();
    basic_inputs();
    link.tx_ready = 1'b0;
    step(1);
    repeat (300) step(1);
    check("ovr_saturated", ovr, 8'd255);
    check("ovr_busy", busy, 1);
    check("ovr_stalled_b0", link.tx_data, 8'hA5);
    d0 = n_done1;
    link.tx_ready = 1'b1;
    wait_done("overrun_drain");
    repeat (20) step(0);
    check("ovr_one_packet", n_done1 - d0, 1);

    // Tick on the B7 transfer edge, then one cycle later
    do_reset();
    link.tx_ready = 1'b1;
    step(1);
    repeat (7) step(0);
    step(1);
    check("bnd_ovr", ovr, 1);
    check("bnd_no_start", busy, 0);
    step(1);
    check("bnd_start", busy, 1);
    check("bnd_ovr_held", ovr, 1);
    wait_done("boundary_drain");

    // Reset mid-packet after B3 transfers
    rand_inputs();
    step(1);
    step(1);
    repeat (3) step(0);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", link.tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovr", ovr, 0);
    check("mid_rst_done", pkt_done, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    step(1);
    check("post_rst_b0", link.tx_data, 8'hA5);
    wait_done("post_reset_drain");

    // SEND_DIV=3: packets on ticks 3, 6 and 9 only
    do_reset();
    d0 = n_done3;
    for (int t = 1; t <= 9; t++) begin
      tick3 = 1'b1;
      @(posedge clk);
      #2;
      tick3 = 1'b0;
      check("div_start", busy3, (t % 3) == 0);
      repeat (20) step(0);
    end
    check("div_packets", n_done3 - d0, 3);
    check("div_ovr", ovr3, 0);

    check("queue_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish within 1 ms");
    $fatal(1);
  end

endmodule
